am29x10_seq: RTL and testbench
==============================

AM29X10_SEQ -- requirements
Module: am29x10_seq

Interface
REQ-001 Parameter WIDTH, default 12: address/data width, legal 4..16.
REQ-002 Parameter DEPTH, default 5: stack entries, legal 2..16.
REQ-003 cp  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 d  in  WIDTH  direct branch address / counter load value.
REQ-006 i  in  4  instruction code, decoded per REQ-012.
REQ-007 cc_  in  1  test condition, active-low (0 = true).
REQ-008 ccen_  in  1  condition enable, active-low; 1 forces pass.
REQ-009 ci  in  1  incrementer carry-in.
REQ-010 rld_  in  1  counter load, active-low; loads R from d unconditionally.
REQ-011 oe_  in  1  y enable, active-low; 1 -> y high-Z.
REQ-011a y  out  WIDTH  next microaddress; full_, empty  out  1  stack flags (full_ active-low); pl_, map_, vect_  out  1  source enables, active-low.

Function
REQ-012 pass = ccen_ | ~cc_; Rz = (R==0); TOS = top stack entry; Y-mux and actions per i:
 0 JZ: Y=0, stack cleared. 1 CJS: pass ? Y=d, push : Y=uPC. 2 JMAP: Y=d.
 3 CJP: pass ? d : uPC. 4 PUSH: Y=uPC, push; pass -> R=d. 5 JSRP: push; Y = pass ? d : R.
 6 CJV: pass ? d : uPC. 7 JRP: pass ? d : R. 8 RFCT: ~Rz ? Y=TOS, R-- : Y=uPC, pop.
 9 RPCT: ~Rz ? Y=d, R-- : Y=uPC. 10 CRTN: pass ? Y=TOS, pop : Y=uPC.
 11 CJPP: pass ? Y=d, pop : Y=uPC. 12 LDCT: Y=uPC, R=d. 13 LOOP: pass ? Y=uPC, pop : Y=TOS.
 14 CONT: Y=uPC. 15 TWB: pass -> Y=uPC, pop; fail&~Rz -> Y=TOS, R--; fail&Rz -> Y=d, pop.
REQ-013 map_=0 only for i=2; vect_=0 only for i=6; pl_=0 otherwise; exactly one low at all times.
REQ-014 Y is combinational from i, cc_, ccen_, d, R, uPC, TOS; zero-cycle latency.
REQ-015 uPC <= Y + ci (mod 2^WIDTH) every clock, regardless of oe_.
REQ-016 R decrements mod 2^WIDTH; rld_=0 overrides any decrement or instruction load that cycle.
REQ-017 Push stores current uPC (pre-update) at sp, then sp+1; pop decrements sp.
REQ-018 Push at full (sp==DEPTH): sp unchanged, top entry overwritten.
REQ-019 Pop at empty (sp==0): no change; TOS reads 0 when empty.
REQ-020 full_=0 iff sp==DEPTH; empty=1 iff sp==0; both registered-state derived.
REQ-021 i=0 clear has priority over any push/pop same cycle.

Reset
REQ-022 rst=1 immediately forces uPC=0, R=0, sp=0, empty=1, full_=1; stack contents need not clear.
REQ-023 rst mid-subroutine discards stack; first edge after release performs normal decode.

Structure
REQ-024 Package am29x10_pkg holds the 16 opcode constants and the pass/Rz helper definitions.
REQ-025 One sub-module am29x10_stack (DEPTH x WIDTH LIFO: push, pop, clr, tos, sp, full, empty).

Verification
REQ-026 rst, then i=14, ci=1 for 3 clocks -> y=0,1,2; uPC=3.
REQ-027 uPC=0x010, i=1, ccen_=0, cc_=0, d=0x200 -> y=0x200, push 0x010; next i=10 pass -> y=0x010 and empty.
REQ-028 i=12 d=3, then i=9 d=0x050 four cycles -> y=0x050 x3, then uPC; R ends 0.
REQ-029 DEPTH=5: six pushes of 1..6 -> full_=0 after 5th, TOS=6; six pops -> empty=1, 6th pop no change.
REQ-030 rld_=0, d=7 during i=8 with R=2 -> R=7 not 1; Y=TOS.
REQ-031 i=15 with R=0, fail, d=0x123 -> y=0x123, pop; oe_=1 -> y=Z while uPC still 0x124 (ci=1).

Source files
------------

// File: rtl/am29x10_pkg.sv
// Shared opcode encoding and condition helpers for the Am29x10-style microprogram sequencer.
package am29x10_pkg;

  typedef enum logic [3:0] {
    OP_JZ   = 4'd0,
    OP_CJS  = 4'd1,
    OP_JMAP = 4'd2,
    OP_CJP  = 4'd3,
    OP_PUSH = 4'd4,
    OP_JSRP = 4'd5,
    OP_CJV  = 4'd6,
    OP_JRP  = 4'd7,
    OP_RFCT = 4'd8,
    OP_RPCT = 4'd9,
    OP_CRTN = 4'd10,
    OP_CJPP = 4'd11,
    OP_LDCT = 4'd12,
    OP_LOOP = 4'd13,
    OP_CONT = 4'd14,
    OP_TWB  = 4'd15
  } op_e;

  function automatic logic cond_pass(input logic ccen_n, input logic cc_n);
    return ccen_n | ~cc_n;
  endfunction

  function automatic logic is_zero(input logic [15:0] v);
    return v == '0;
  endfunction

endpackage

// File: rtl/am29x10_stack.sv
// DEPTH x WIDTH LIFO for subroutine/loop return addresses; push at full overwrites the top entry.
module am29x10_stack #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] tos_o,
  output logic             full_o,
  output logic             empty_o
);
  import am29x10_pkg::*;

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned AW  = $clog2(DEPTH);

  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_idx, rd_idx;

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign rd_idx  = AW'(sp_q - SPW'(1));
  assign wr_idx  = full_o ? AW'(DEPTH - 1) : AW'(sp_q);
  assign tos_o   = empty_o ? '0 : mem_q[rd_idx];

  always_comb begin
    sp_d = sp_q;
    if (clr_i) begin
      sp_d = '0;
    end else if (push_i && !full_o) begin
      sp_d = sp_q + SPW'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Contents are not reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) begin
      mem_q[wr_idx] <= din_i;
    end
  end

endmodule

// File: rtl/am29x10_seq.sv
// Microprogram sequencer: combinational next-address mux over d/R/uPC/TOS plus
// registered uPC, loop counter R and return-address stack.
module am29x10_seq #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 5
) (
  input  logic             cp,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic [3:0]       i,
  input  logic             cc_,
  input  logic             ccen_,
  input  logic             ci,
  input  logic             rld_,
  input  logic             oe_,
  output logic [WIDTH-1:0] y,
  output logic             full_,
  output logic             empty,
  output logic             pl_,
  output logic             map_,
  output logic             vect_
);
  import am29x10_pkg::*;

  op_e              op;
  logic             pass, rz;
  logic [WIDTH-1:0] upc_q, upc_d, r_q, r_d, tos, y_int;
  logic             push, pop, clr, r_ld, r_dec;
  logic             stk_full, stk_empty;

  assign op   = op_e'(i);
  assign pass = cond_pass(ccen_, cc_);
  assign rz   = is_zero(16'(r_q));

  always_comb begin
    y_int = upc_q;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    r_ld  = 1'b0;
    r_dec = 1'b0;
    case (op)
      OP_JZ:   begin y_int = '0; clr = 1'b1; end
      OP_CJS:  if (pass) begin y_int = d; push = 1'b1; end
      OP_JMAP: y_int = d;
      OP_CJP:  if (pass) y_int = d;
      OP_PUSH: begin push = 1'b1; r_ld = pass; end
      OP_JSRP: begin push = 1'b1; y_int = pass ? d : r_q; end
      OP_CJV:  if (pass) y_int = d;
      OP_JRP:  y_int = pass ? d : r_q;
      OP_RFCT: if (!rz) begin y_int = tos; r_dec = 1'b1; end
               else pop = 1'b1;
      OP_RPCT: if (!rz) begin y_int = d; r_dec = 1'b1; end
      OP_CRTN: if (pass) begin y_int = tos; pop = 1'b1; end
      OP_CJPP: if (pass) begin y_int = d; pop = 1'b1; end
      OP_LDCT: r_ld = 1'b1;
      OP_LOOP: if (pass) pop = 1'b1;
               else y_int = tos;
      OP_CONT: y_int = upc_q;
      OP_TWB:  if (pass) pop = 1'b1;
               else if (!rz) begin y_int = tos; r_dec = 1'b1; end
               else begin y_int = d; pop = 1'b1; end
      default: y_int = upc_q;
    endcase
  end

  // External load wins over any instruction-driven load or decrement.
  always_comb begin
    r_d = r_q;
    if (!rld_ || r_ld) begin
      r_d = d;
    end else if (r_dec) begin
      r_d = r_q - WIDTH'(1);
    end
  end

  assign upc_d = y_int + WIDTH'(ci);

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      upc_q <= '0;
      r_q   <= '0;
    end else begin
      upc_q <= upc_d;
      r_q   <= r_d;
    end
  end

  am29x10_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_stack (
    .clk    (cp),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .clr_i  (clr),
    .din_i  (upc_q),
    .tos_o  (tos),
    .full_o (stk_full),
    .empty_o(stk_empty)
  );

  assign y     = oe_ ? 'z : y_int;
  assign full_ = ~stk_full;
  assign empty = stk_empty;
  assign map_  = ~(op == OP_JMAP);
  assign vect_ = ~(op == OP_CJV);
  assign pl_   = (op == OP_JMAP) || (op == OP_CJV);

endmodule

// File: tb/tb_am29x10_seq.sv
// Directed-vector bench for am29x10_seq with hand-computed expected addresses and flags.
module tb_am29x10_seq;

  logic        cp = 1'b0;
  logic        rst;
  logic [11:0] d;
  logic [3:0]  i;
  logic        cc_, ccen_, ci, rld_, oe_;
  logic [11:0] y;
  logic        full_, empty, pl_, map_, vect_;

  int total = 0;
  int bad   = 0;

  am29x10_seq #(.WIDTH(12), .DEPTH(5)) dut (
    .cp(cp), .rst(rst), .d(d), .i(i), .cc_(cc_), .ccen_(ccen_), .ci(ci),
    .rld_(rld_), .oe_(oe_), .y(y), .full_(full_), .empty(empty),
    .pl_(pl_), .map_(map_), .vect_(vect_)
  );

  always #5 cp = ~cp;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  initial begin
    logic [11:0] pop_exp [6];
    pop_exp[0] = 12'h006; pop_exp[1] = 12'h004; pop_exp[2] = 12'h003;
    pop_exp[3] = 12'h002; pop_exp[4] = 12'h001; pop_exp[5] = 12'h000;

    rst = 1'b1; d = '0; i = 4'd14; cc_ = 1'b1; ccen_ = 1'b1;
    ci = 1'b1; rld_ = 1'b1; oe_ = 1'b0;
    #2;
    chk("rst_y", y, 16'h000);
    chk("rst_empty", empty, 1);
    chk("rst_full_", full_, 1);
    chk("rst_pl_", pl_, 0);
    #10 rst = 1'b0;

    // CONT from reset: 0,1,2 then uPC=3
    chk("cont0", y, 16'h000); tick();
    chk("cont1", y, 16'h001); tick();
    chk("cont2", y, 16'h002); tick();
    chk("cont3", y, 16'h003);

    ccen_ = 1'b0; cc_ = 1'b1; i = 4'd3; d = 12'h777; #1;
    chk("cjp_fail", y, 16'h003);
    cc_ = 1'b0; #1;
    chk("cjp_pass", y, 16'h777);

    i = 4'd2; d = 12'h00F; #1;
    chk("jmap_y", y, 16'h00F);
    chk("jmap_map_", map_, 0);
    chk("jmap_pl_", pl_, 1);
    tick();

    // CJS pass pushes uPC=0x010, CRTN returns to it
    i = 4'd1; d = 12'h200; #1;
    chk("cjs_y", y, 16'h200);
    tick();
    chk("cjs_empty", empty, 0);
    i = 4'd10; #1;
    chk("crtn_y", y, 16'h010);
    tick();
    chk("crtn_empty", empty, 1);

    i = 4'd12; d = 12'h003; #1;
    chk("ldct_y", y, 16'h011);
    tick();
    i = 4'd9; d = 12'h050; #1;
    for (int k = 0; k < 3; k++) begin
      chk("rpct_loop", y, 16'h050);
      tick();
    end
    chk("rpct_exit", y, 16'h051);
    tick();
    i = 4'd7; ccen_ = 1'b0; cc_ = 1'b1; #1;
    chk("r_end_zero", y, 16'h000);

    i = 4'd2; d = 12'h000; tick();
    i = 4'd4; ccen_ = 1'b0; cc_ = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk("push_y", y, 16'(k));
      tick();
      if (k == 4) chk("push4_full_", full_, 1);
      if (k >= 5) chk("push_full_", full_, 0);
    end
    i = 4'd13; #1;
    chk("loop_tos", y, 16'h006);

    i = 4'd10; ccen_ = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("pop_y", y, 16'(pop_exp[k]));
      tick();
      if (k == 0) chk("pop_full_", full_, 1);
      if (k >= 4) chk("pop_empty", empty, 1);
    end

    // Counter load during RFCT overrides decrement
    i = 4'd12; d = 12'h002; tick();
    i = 4'd2; d = 12'h0AA; tick();
    i = 4'd4; ccen_ = 1'b0; cc_ = 1'b1; tick();
    i = 4'd8; rld_ = 1'b0; d = 12'h007; #1;
    chk("rfct_tos", y, 16'h0AB);
    tick();
    rld_ = 1'b1;
    chk("rfct_nopop", empty, 0);
    i = 4'd7; #1;
    chk("rld_override", y, 16'h007);
    tick();

    i = 4'd12; d = 12'h000; tick();
    i = 4'd15; d = 12'h123; #1;
    chk("twb_y", y, 16'h123);
    tick();
    chk("twb_pop", empty, 1);
    i = 4'd14; oe_ = 1'b1; #1;
    total++;
    assert (y === 12'bz) else begin
      bad++;
      $error("FAIL y_hiz observed=%h expected=zzz", y);
    end
    oe_ = 1'b0; #1;
    chk("upc_hold", y, 16'h124);

    i = 4'd6; ccen_ = 1'b1; d = 12'h0C3; #1;
    chk("cjv_y", y, 16'h0C3);
    chk("cjv_vect_", vect_, 0);
    chk("cjv_pl_", pl_, 1);

    i = 4'd4; ccen_ = 1'b0; cc_ = 1'b1; tick();
    chk("pre_jz_empty", empty, 0);
    i = 4'd0; #1;
    chk("jz_y", y, 16'h000);
    tick();
    chk("jz_clear", empty, 1);

    // Reset in the middle of a subroutine
    i = 4'd4; tick();
    i = 4'd14; rst = 1'b1; #2;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_y", y, 16'h000);
    #2 rst = 1'b0;
    tick();
    chk("post_rst_y", y, 16'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
